accum_lock_ctrl: RTL

- Accumulate-side lock controller; sits directly upstream of the key mutex and owns the accumulate half of its handshake.
- Accepts (key, delta) updates from the accumulate input path.
- Requests the key through the mutex and holds the lock for the whole memory operation.
- Performs a read-modify-write (value += delta) on the key's state word, then releases the lock.

---
 rtl/accum_lock_ctrl_if.sv | 42 ++++
 rtl/accum_lock_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/accum_lock_ctrl_if.sv
// Accumulate-side bundle: update input, mutex handshake, memory read/write port and status.
// master = environment side, slave = accum_lock_ctrl.
interface accum_lock_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 31,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned KEY_WIDTH   = 32;
  localparam int unsigned COUNT_WIDTH = 32;

  logic                     in_valid;
  logic                     in_ready;
  logic [KEY_WIDTH-1:0]     in_key;
  logic [DATA_WIDTH-1:0]    in_delta;
  logic                     grant_accum;
  logic                     accum_key_locked;
  logic [KEY_WIDTH-1:0]     accum_key;
  logic [KEY_WIDTH-1:0]     locked_accum_key;
  logic                     mem_rd_req;
  logic [ADDRESS_WIDTH-1:0] mem_rd_addr;
  logic                     mem_rd_valid;
  logic [DATA_WIDTH-1:0]    mem_rd_data;
  logic                     mem_wr_req;
  logic [ADDRESS_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0]    mem_wr_data;
  logic                     mem_wr_ack;
  logic                     done;
  logic [COUNT_WIDTH-1:0]   stall_count;

  modport master (
    output in_valid, in_key, in_delta, grant_accum, accum_key_locked,
           mem_rd_valid, mem_rd_data, mem_wr_ack,
    input  in_ready, accum_key, locked_accum_key, mem_rd_req, mem_rd_addr,
           mem_wr_req, mem_wr_addr, mem_wr_data, done, stall_count
  );

  modport slave (
    input  in_valid, in_key, in_delta, grant_accum, accum_key_locked,
           mem_rd_valid, mem_rd_data, mem_wr_ack,
    output in_ready, accum_key, locked_accum_key, mem_rd_req, mem_rd_addr,
           mem_wr_req, mem_wr_addr, mem_wr_data, done, stall_count
  );
endinterface

// File: rtl/accum_lock_ctrl.sv
// Accumulate-side lock controller: acquires a key through the mutex, performs
// value += delta on the key's state word, then releases the lock.
module accum_lock_ctrl #(
  parameter int unsigned              ADDRESS_WIDTH = 31,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter logic [31:0]              NULL_KEY      = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic reset,
  accum_lock_ctrl_if.slave bus
);

  localparam int unsigned COUNT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    READ,
    WAIT_RD,
    WRITE,
    RELEASE,
    DONE
  } state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    delta_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] in_addr;

  // Key-to-word mapping; upper key bits beyond the address width are dropped.
  assign in_addr = ADDRESS_WIDTH'(BASE_ADDR + bus.in_key[ADDRESS_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      delta_q              <= '0;
      addr_q               <= '0;
      bus.in_ready         <= 1'b1;
      bus.accum_key        <= NULL_KEY;
      bus.locked_accum_key <= NULL_KEY;
      bus.mem_rd_req       <= 1'b0;
      bus.mem_rd_addr      <= '0;
      bus.mem_wr_req       <= 1'b0;
      bus.mem_wr_addr      <= '0;
      bus.mem_wr_data      <= '0;
      bus.done             <= 1'b0;
      bus.stall_count      <= '0;
    end else begin
      bus.mem_rd_req <= 1'b0;
      bus.done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            delta_q      <= bus.in_delta;
            addr_q       <= in_addr;
            bus.in_ready <= 1'b0;
            // A null key is acknowledged without touching the lock or memory.
            if (bus.in_key == NULL_KEY) begin
              state <= DONE;
            end else begin
              bus.accum_key <= bus.in_key;
              state         <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (bus.grant_accum) begin
            if (!bus.accum_key_locked) begin
              bus.locked_accum_key <= bus.accum_key;
              bus.mem_rd_req       <= 1'b1;
              bus.mem_rd_addr      <= addr_q;
              state                <= READ;
            end else if (bus.stall_count != '1) begin
              bus.stall_count <= COUNT_WIDTH'(bus.stall_count + 32'd1);
            end
          end
        end
        READ: begin
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (bus.mem_rd_valid) begin
            bus.mem_wr_data <= DATA_WIDTH'(bus.mem_rd_data + delta_q);
            bus.mem_wr_addr <= addr_q;
            bus.mem_wr_req  <= 1'b1;
            state           <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_wr_ack) begin
            bus.mem_wr_req <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          bus.locked_accum_key <= NULL_KEY;
          bus.accum_key        <= NULL_KEY;
          state                <= DONE;
        end
        DONE: begin
          bus.done     <= 1'b1;
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
